// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, latches IF/ID.
// Resolves jump/halt locally; honours downstream stall and redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  JUMP_OPCODE = 6'b000101,
  parameter logic [31:0] NOP_WORD    = 32'h30000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instrucao,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Endereco,
  output logic [31:0] IR,
  output logic [31:0] PCOut,
  output logic        Valid,
  output logic        Halted,
  output logic [31:0] InstrCount
);

  localparam int unsigned W      = 32;
  localparam int unsigned TGT_W  = 26;

  typedef enum logic {RUN, HALT} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_pc, w_pc_nxt;
  logic [W-1:0]   r_ir, w_ir_nxt;
  logic [W-1:0]   r_pcout, w_pcout_nxt;
  logic           r_valid, w_valid_nxt;
  logic [W-1:0]   r_count, w_count_nxt;

  logic           w_is_jump;
  logic [W-1:0]   w_target;
  logic           w_is_halt;

  // Predecode: a halt is a jump whose target is its own address
  assign w_is_jump = (Instrucao[31:26] == JUMP_OPCODE);
  assign w_target  = W'(Instrucao[TGT_W-1:0]);
  assign w_is_halt = w_is_jump && (w_target == r_pc);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_ir    <= NOP_WORD;
      r_pcout <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_pcout <= w_pcout_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state: redirect > stall > halted > normal fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_pcout_nxt = r_pcout;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;

    if (Redirect) begin
      w_state_nxt = RUN;
      w_pc_nxt    = RedirectTarget;
      w_ir_nxt    = NOP_WORD;
      w_valid_nxt = 1'b0;
    end else if (Stall) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        HALT: begin
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_ir_nxt    = Instrucao;
          w_pcout_nxt = r_pc;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count + W'(1);
          if (w_is_halt) begin
            w_state_nxt = HALT;
          end else if (w_is_jump) begin
            w_pc_nxt = w_target;
          end else begin
            w_pc_nxt = r_pc + W'(1);
          end
        end
      endcase
    end
  end

  assign Endereco   = r_pc;
  assign IR         = r_ir;
  assign PCOut      = r_pcout;
  assign Valid      = r_valid;
  assign Halted     = (r_state == HALT);
  assign InstrCount = r_count;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the Yousei processor, directly upstream of the instruction memory. It owns the program counter and drives the memory address, latching the returned word into an IF/ID register with a valid flag. It resolves unconditional `jump` (and `halt`) locally with zero bubbles, and accepts stall and redirect requests from later stages for `beq` and `jr`. Memory read is combinational from the address, so each fetch completes in one cycle.

## Interface
- RESET_PC, default 32'd0: PC value loaded on reset.
- JUMP_OPCODE, default 6'b000101: opcode field [31:26] of `jump` and `halt`.
- NOP_WORD, default 32'h30000000: IR contents on reset and on flush.
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Instrucao  in  32  word returned by instruction memory for the current Endereco.
- Stall  in  1  hold all fetch state this cycle.
- Redirect  in  1  downstream taken `beq` or `jr`; load RedirectTarget and flush.
- RedirectTarget  in  32  absolute word address for Redirect.
- Endereco  out  32  instruction memory address; combinational copy of PC.
- IR  out  32  latched instruction (IF/ID).
- PCOut  out  32  address IR was fetched from.
- Valid  out  1  IR holds a live instruction.
- Halted  out  1  sticky halt indication.
- InstrCount  out  32  count of instructions latched with Valid=1.

## Operation
- Jump detect is combinational: `isJump = Instrucao[31:26]==JUMP_OPCODE`. The target is `{6'b0, Instrucao[25:0]}`.
- Halt detect: `isJump && target==PC`. The halt encoding is a jump to itself.
- Per-cycle priority, highest first:
  - Reset: PC=RESET_PC, IR=NOP_WORD, PCOut=0, Valid=0, Halted=0, InstrCount=0.
  - Redirect: PC<=RedirectTarget, IR<=NOP_WORD, Valid<=0, Halted<=0. Redirect overrides Stall and Halted, because the halt may have been fetched on a wrong path.
  - Stall: PC, IR, PCOut, Valid, Halted and InstrCount all hold.
  - Halted: PC holds, Valid<=0, IR holds.
  - Normal fetch: IR<=Instrucao, PCOut<=PC, Valid<=1, InstrCount<=InstrCount+1.
    - If halt: Halted<=1 and PC holds. The halt word itself is emitted once with Valid=1.
    - Else if isJump: PC<=target.
    - Else: PC<=PC+1.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFF+1 wraps to 0. InstrCount also wraps.
- States: RUN (Halted=0) and HALT (Halted=1).
  - RUN→HALT on a normal fetch of a halt word.
  - HALT→RUN only on Redirect or Reset.
- `beq` and `jr` are not predecoded. They fall through to PC+1 until Redirect arrives.

## Timing
- Endereco = PC combinationally. There is zero latency from a PC update to the memory address.
- Instruction fetched at cycle n appears on IR/PCOut/Valid after posedge n, i.e. with 1-cycle latency.
- A taken jump costs 0 bubbles.
- Redirect costs 1 bubble: the flushed slot (Valid=0) plus the normal 1-cycle latency at the target.
- Memory contents load on the first clock edge. Reset must be held for ≥1 posedge so the first post-reset fetch sees loaded memory.
- Reset released at edge k: Endereco=RESET_PC during cycle k, and IR is valid after edge k+1.
- A Reset asserted mid-stall, mid-halt or concurrent with Redirect wins unconditionally.
- Stall and Redirect asserted together: Redirect takes effect and Stall is ignored.

## Test plan
- Reset release with the shipped program: Endereco 0→1→2. IR=32'h0801001A, PCOut=0, Valid=1 after the first edge. InstrCount=1.
- Jump predecode: fetch at address 2 (32'h14000065). On the next cycle Endereco=101 (0x65) with no Valid=0 gap. IR=32'h14000065, PCOut=2.
- Halt: PC reaches 149 (32'h14000095).
  - IR=32'h14000095 with Valid=1 and Halted=1.
  - Afterwards Endereco stays 149 and Valid=0 for 10+ cycles.
  - InstrCount stops incrementing.
- Redirect: at PC=22 assert Redirect with RedirectTarget=45.
  - Next cycle: Endereco=45, Valid=0, IR=32'h30000000.
  - Following cycle: PCOut=45, Valid=1.
- Stall: assert Stall for 3 cycles at PC=10. Endereco, IR, PCOut, Valid and InstrCount are unchanged. Release resumes at 11.
- Corner cases:
  - Redirect to 0 while Halted: Halted clears and fetch resumes at 0.
  - Reset asserted concurrently with Redirect: all outputs return to reset values.
  - PC=32'hFFFFFFFF non-jump: wraps to 0.
